// File: rtl/key_debounce.sv
// Four-channel pushbutton debouncer: 2-flop synchronizer plus per-key filter FSM.
// Optional long-press pulse generation is enabled by defining KEY_LONG_PRESS_EN.
`timescale 1ns/1ps

module key_debounce #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    output logic [3:0] key_value,
    output logic [3:0] key_flag,
    output logic [3:0] key_long
);

    typedef enum logic [1:0] {
        HIGH    = 2'd0,
        FILT_DN = 2'd1,
        LOW     = 2'd2,
        FILT_UP = 2'd3
    } state_t;

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
`ifdef KEY_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    localparam int CNT_W  = (DEB_W > LONG_W) ? DEB_W : LONG_W;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);
`else
    localparam int CNT_W = DEB_W;
`endif
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Parameter sanity: the filter needs at least two samples to be meaningful.
    if (DEB_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_param
        $error("key_debounce: DEB_CYCLES must be >= 2 and LONG_CYCLES >= 1");
    end

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    state_t           state_q [4];
    state_t           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       key_value_q, key_value_d;
    logic [3:0]       key_flag_q, key_flag_d;
`ifdef KEY_LONG_PRESS_EN
    logic [3:0]       key_long_q, key_long_d;
    logic [3:0]       long_done_q, long_done_d;
`endif

    always_comb begin
        sync1_d     = key_in;
        sync2_d     = sync1_q;
        key_value_d = key_value_q;
        key_flag_d  = 4'b0000;
`ifdef KEY_LONG_PRESS_EN
        key_long_d  = 4'b0000;
        long_done_d = long_done_q;
`endif
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                HIGH: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = FILT_DN;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                FILT_DN: begin
                    if (sync2_q[i]) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= DEB_LAST) begin
                        state_d[i]     = LOW;
                        cnt_d[i]       = '0;
                        key_value_d[i] = 1'b0;
                        key_flag_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                LOW: begin
                    if (sync2_q[i]) begin
                        state_d[i] = FILT_UP;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
`ifdef KEY_LONG_PRESS_EN
                        // Keep counting the hold time; fire once, then saturate.
                        if (cnt_q[i] < LONG_LAST) begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end else if (cnt_q[i] == LONG_LAST) begin
                            cnt_d[i] = LONG_SAT;
                            if (!long_done_q[i]) begin
                                key_long_d[i]  = 1'b1;
                                long_done_d[i] = 1'b1;
                            end
                        end
`else
                        cnt_d[i] = '0;
`endif
                    end
                end
                FILT_UP: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= DEB_LAST) begin
                        state_d[i]     = HIGH;
                        cnt_d[i]       = '0;
                        key_value_d[i] = 1'b1;
                        key_flag_d[i]  = 1'b1;
`ifdef KEY_LONG_PRESS_EN
                        long_done_d[i] = 1'b0;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = HIGH;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            key_value_q <= 4'b1111;
            key_flag_q  <= 4'b0000;
`ifdef KEY_LONG_PRESS_EN
            key_long_q  <= 4'b0000;
            long_done_q <= 4'b0000;
`endif
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= HIGH;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            key_value_q <= key_value_d;
            key_flag_q  <= key_flag_d;
`ifdef KEY_LONG_PRESS_EN
            key_long_q  <= key_long_d;
            long_done_q <= long_done_d;
`endif
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign key_value = key_value_q;
    assign key_flag  = key_flag_q;
`ifdef KEY_LONG_PRESS_EN
    assign key_long  = key_long_q;
`else
    assign key_long  = 4'b0000;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEB_CYCLES=8, LONG_CYCLES=20.
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_key_debounce;

    localparam int DEB  = 8;
    localparam int LONG = 20;
`ifdef KEY_LONG_PRESS_EN
    localparam logic [3:0] LONG_EXP = 4'b1100;
`else
    localparam logic [3:0] LONG_EXP = 4'b0000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_in = 4'b1111;
    logic [3:0] key_value;
    logic [3:0] key_flag;
    logic [3:0] key_long;

    int checks = 0;
    int errors = 0;

    key_debounce #(
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_value(key_value),
        .key_flag (key_flag),
        .key_long (key_long)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] keys, input logic rstVal);
        key_in = keys;
        rst    = rstVal;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expValue,
                               input logic [3:0] expFlag, input logic [3:0] expLong);
        checks++;
        assert (key_value === expValue) else begin
            errors++;
            $error("[TB] FAIL %s key_value: observed %b expected %b", tag, key_value, expValue);
        end
        checks++;
        assert (key_flag === expFlag) else begin
            errors++;
            $error("[TB] FAIL %s key_flag: observed %b expected %b", tag, key_flag, expFlag);
        end
        checks++;
        assert (key_long === expLong) else begin
            errors++;
            $error("[TB] FAIL %s key_long: observed %b expected %b", tag, key_long, expLong);
        end
    endtask

    // Input changed at the current falling edge: the flag must show up on the 10th one after.
    task automatic expectTransition(input string tag, input logic [3:0] oldValue,
                                    input logic [3:0] newValue, input logic [3:0] mask,
                                    input bit isPress);
        for (int i = 1; i <= DEB + 1; i++) begin
            @(negedge clk);
            checkOutput(tag, oldValue, 4'b0000, 4'b0000);
        end
        @(negedge clk);
        checkOutput(tag, newValue, mask, 4'b0000);
        checks++;
        if (isPress) begin
            assert ((key_flag & ~key_value) === mask) else begin
                errors++;
                $error("[TB] FAIL %s press_decode: observed %b expected %b",
                       tag, key_flag & ~key_value, mask);
            end
        end else begin
            assert ((key_flag & key_value) === mask) else begin
                errors++;
                $error("[TB] FAIL %s release_decode: observed %b expected %b",
                       tag, key_flag & key_value, mask);
            end
        end
        @(negedge clk);
        checkOutput(tag, newValue, 4'b0000, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        applyStimulus(4'b1111, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("reset", 4'b1111, 4'b0000, 4'b0000);

        applyStimulus(4'b1111, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("idle", 4'b1111, 4'b0000, 4'b0000);
        end

        // Stable press and release of key 0
        applyStimulus(4'b1110, 1'b0);
        expectTransition("press0", 4'b1111, 4'b1110, 4'b0001, 1'b1);
        applyStimulus(4'b1111, 1'b0);
        expectTransition("release0", 4'b1110, 4'b1111, 4'b0001, 1'b0);

        // Key 1 bounces in 3-cycle runs, then settles low
        for (int seg = 0; seg < 10; seg++) begin
            applyStimulus((seg % 2 == 0) ? 4'b1101 : 4'b1111, 1'b0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                checkOutput("bounce1", 4'b1111, 4'b0000, 4'b0000);
            end
        end
        applyStimulus(4'b1101, 1'b0);
        expectTransition("bounce1_settle", 4'b1111, 4'b1101, 4'b0010, 1'b1);
        applyStimulus(4'b1111, 1'b0);
        expectTransition("release1", 4'b1101, 4'b1111, 4'b0010, 1'b0);

        // Keys 3 and 2 together, held 40 cycles for the long-press check
        applyStimulus(4'b0011, 1'b0);
        expectTransition("simul32", 4'b1111, 4'b0011, 4'b1100, 1'b1);
        for (int i = 12; i <= 29; i++) begin
            @(negedge clk);
            checkOutput("hold32", 4'b0011, 4'b0000, 4'b0000);
        end
        @(negedge clk);
        checkOutput("long32", 4'b0011, 4'b0000, LONG_EXP);
        for (int i = 31; i <= 40; i++) begin
            @(negedge clk);
            checkOutput("long32_once", 4'b0011, 4'b0000, 4'b0000);
        end
        applyStimulus(4'b1111, 1'b0);
        expectTransition("release32", 4'b0011, 4'b1111, 4'b1100, 1'b0);

        // Reset pulsed five cycles into a press of key 0
        applyStimulus(4'b1110, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("prefilter0", 4'b1111, 4'b0000, 4'b0000);
        end
        applyStimulus(4'b1110, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst_midfilter", 4'b1111, 4'b0000, 4'b0000);
        end
        applyStimulus(4'b1110, 1'b0);
        expectTransition("rst_resume0", 4'b1111, 4'b1110, 4'b0001, 1'b1);

        // Reset while key 0 is accepted as pressed
        applyStimulus(4'b1110, 1'b1);
        @(negedge clk);
        checkOutput("rst_midpress", 4'b1111, 4'b0000, 4'b0000);
        applyStimulus(4'b1110, 1'b0);
        expectTransition("rst_repress0", 4'b1111, 4'b1110, 4'b0001, 1'b1);
        applyStimulus(4'b1111, 1'b0);
        expectTransition("final_release0", 4'b1110, 4'b1111, 4'b0001, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
